// File: rtl/gpu_irq_controller.sv
// GPU interrupt controller. Latches per-source IRQ pulses into pending bits,
// applies a software mask, and raises one level interrupt for the lowest
// active source. The interrupt is held until the host acks it, then a
// hold-off gap follows before the next assertion. A pulse on a source that
// is already pending sets a sticky overflow flag.
module gpu_irq_controller #(
  parameter int unsigned        NUM_SRC     = 8,
  parameter int unsigned        HOLDOFF_CYC = 4,
  parameter logic [NUM_SRC-1:0] MASK_RST    = '1,
  localparam int unsigned       ID_W        = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_pulse_i,
  input  logic               mask_wr_i,
  input  logic [NUM_SRC-1:0] mask_data_i,
  input  logic               ack_i,
  input  logic [ID_W-1:0]    ack_id_i,
  output logic               irq_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic [NUM_SRC-1:0] overflow_o,
  output logic [NUM_SRC-1:0] mask_o
);

  localparam int unsigned CNT_W = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;

  typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] ack_hit;
  logic [NUM_SRC-1:0] active;
  logic [ID_W-1:0]    lowest_id;

  assign active = pend_q & mask_q;

  // Decode the ack strobe per source; ids with no matching source never hit.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ack_hit[i] = ack_i && (ack_id_i == ID_W'(i));
    end
  end

  // Pending/overflow/mask next state; a same-cycle pulse beats the ack.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    mask_d = mask_wr_i ? mask_data_i : mask_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      pend_d[i] = irq_pulse_i[i] | (pend_q[i] & ~ack_hit[i]);
      if (irq_pulse_i[i] && ack_hit[i]) begin
        ovf_d[i] = ovf_q[i];
      end else if (irq_pulse_i[i] && pend_q[i]) begin
        ovf_d[i] = 1'b1;
      end else if (ack_hit[i]) begin
        ovf_d[i] = 1'b0;
      end
    end
  end

  // Source register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      mask_q <= MASK_RST;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      mask_q <= mask_d;
    end
  end

  // Priority pick: lowest-index active source.
  always_comb begin
    lowest_id = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) lowest_id = ID_W'(i);
    end
  end

  // FSM state, hold-off counter and latched source id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      irq_id_q <= irq_id_d;
    end
  end

  // FSM next state; the id is frozen while asserted (no re-prioritisation).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    irq_id_d = irq_id_q;
    case (state_q)
      StIdle: begin
        if (|active) begin
          state_d  = StAssert;
          irq_id_d = lowest_id;
        end
      end
      StAssert: begin
        if (ack_i && (ack_id_i == irq_id_q)) begin
          if (HOLDOFF_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StHoldoff;
            cnt_d   = CNT_W'(HOLDOFF_CYC);
          end
        end else if (!active[irq_id_q]) begin
          // Source masked or cleared by other means: drop without hold-off.
          state_d = StIdle;
        end
      end
      StHoldoff: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded straight from registers.
  always_comb begin
    irq_o      = (state_q == StAssert);
    irq_id_o   = irq_id_q;
    pending_o  = pend_q;
    overflow_o = ovf_q;
    mask_o     = mask_q;
  end

endmodule

// File: tb/tb_gpu_irq_controller.sv
// Scoreboard bench for gpu_irq_controller: a behavioural model predicts the
// outputs after every clock edge; a monitor pops and compares each cycle.
module tb_gpu_irq_controller;

  localparam int NSRC = 8;
  localparam int HOLD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] irq_pulse_i = '0;
  logic            mask_wr_i = 1'b0;
  logic [NSRC-1:0] mask_data_i = '0;
  logic            ack_i = 1'b0;
  logic [2:0]      ack_id_i = '0;
  logic            irq_o;
  logic [2:0]      irq_id_o;
  logic [NSRC-1:0] pending_o;
  logic [NSRC-1:0] overflow_o;
  logic [NSRC-1:0] mask_o;

  gpu_irq_controller #(
    .NUM_SRC    (NSRC),
    .HOLDOFF_CYC(HOLD),
    .MASK_RST   (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_pulse_i(irq_pulse_i),
    .mask_wr_i  (mask_wr_i),
    .mask_data_i(mask_data_i),
    .ack_i      (ack_i),
    .ack_id_i   (ack_id_i),
    .irq_o      (irq_o),
    .irq_id_o   (irq_id_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .mask_o     (mask_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            irq;
    logic [2:0]      id;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] ovf;
    logic [NSRC-1:0] mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: event flags and the host-visible interrupt.
  bit   m_pend[NSRC];
  bit   m_ovf[NSRC];
  bit   m_mask[NSRC];
  bit   m_on;
  int   m_id;
  int   m_quiet;   // low cycles still owed after an ack

  function automatic void model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_pend[i] = 0;
      m_ovf[i]  = 0;
      m_mask[i] = 1;
    end
    m_on = 0; m_id = 0; m_quiet = 0;
  endfunction

  function automatic void model_step(bit r, logic [NSRC-1:0] p, bit mw, logic [NSRC-1:0] md,
                                     bit a, int aid);
    bit act[NSRC];
    bit any;
    if (r) begin
      model_reset();
      return;
    end
    any = 0;
    for (int i = 0; i < NSRC; i++) begin
      act[i] = m_pend[i] && m_mask[i];
      any    = any || act[i];
    end
    // Interrupt line, judged on the values held before this edge.
    if (m_on) begin
      if (a && aid == m_id) begin
        m_on = 0; m_quiet = HOLD;
      end else if (!act[m_id]) begin
        m_on = 0; m_quiet = 0;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (any) begin
      m_on = 1;
      for (int i = 0; i < NSRC; i++) if (act[i]) begin m_id = i; break; end
    end
    for (int i = 0; i < NSRC; i++) begin
      bit acked = a && (aid == i);
      if (p[i] && acked) begin
        m_pend[i] = 1;
      end else if (p[i]) begin
        if (m_pend[i]) m_ovf[i] = 1;
        m_pend[i] = 1;
      end else if (acked) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
      end
      if (mw) m_mask[i] = md[i];
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.irq = m_on;
    e.id  = 3'(m_id);
    for (int i = 0; i < NSRC; i++) begin
      e.pend[i] = m_pend[i];
      e.ovf[i]  = m_ovf[i];
      e.mask[i] = m_mask[i];
    end
    return e;
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic step(bit r, logic [NSRC-1:0] p, bit mw, logic [NSRC-1:0] md, bit a, int aid);
    @(negedge clk);
    rst         = r;
    irq_pulse_i = p;
    mask_wr_i   = mw;
    mask_data_i = md;
    ack_i       = a;
    ack_id_i    = 3'(aid);
    model_step(r, p, mw, md, a, aid);
    q.push_back(model_out());
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, '0, 0, 0);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against the queued prediction each cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("irq_o", 32'(irq_o), 32'(e.irq));
      if (e.irq) chk("irq_id_o", 32'(irq_id_o), 32'(e.id));
      chk("pending_o", 32'(pending_o), 32'(e.pend));
      chk("overflow_o", 32'(overflow_o), 32'(e.ovf));
      chk("mask_o", 32'(mask_o), 32'(e.mask));
    end
  end

  initial begin
    logic [NSRC-1:0] p, md;
    bit a, mw, r;
    int aid;
    model_reset();
    step(1, '0, 0, '0, 0, 0);
    step(1, '0, 0, '0, 0, 0);
    idle(2);
    // Single source, ack, hold-off.
    step(0, 8'h08, 0, '0, 0, 0);
    idle(3);
    step(0, '0, 0, '0, 1, 3);
    idle(7);
    // Simultaneous pulses: lower index first, then the other after hold-off.
    step(0, 8'h24, 0, '0, 0, 0);
    idle(3);
    step(0, '0, 0, '0, 1, 2);
    idle(7);
    step(0, '0, 0, '0, 1, 5);
    idle(6);
    // Masked pending, then enable.
    step(0, '0, 1, 8'h00, 0, 0);
    step(0, 8'h02, 0, '0, 0, 0);
    idle(3);
    step(0, '0, 1, 8'h02, 0, 0);
    idle(3);
    step(0, '0, 0, '0, 1, 1);
    idle(6);
    step(0, '0, 1, 8'hFF, 0, 0);
    // Overflow and the pulse-beats-ack rule.
    step(0, 8'h10, 0, '0, 0, 0);
    idle(1);
    step(0, 8'h10, 0, '0, 0, 0);
    idle(1);
    step(0, 8'h10, 0, '0, 1, 4);
    idle(6);
    step(0, '0, 0, '0, 1, 4);
    idle(6);
    // Mask drops an asserted source without hold-off; stray ack is harmless.
    step(0, 8'h01, 0, '0, 0, 0);
    idle(3);
    step(0, '0, 1, 8'hFE, 0, 0);
    idle(2);
    step(0, '0, 0, '0, 1, 7);
    step(0, '0, 1, 8'hFF, 0, 0);
    idle(3);
    step(0, '0, 0, '0, 1, 0);
    idle(6);
    // Reset while asserted with overflow set.
    step(0, 8'h04, 0, '0, 0, 0);
    step(0, 8'h04, 0, '0, 0, 0);
    idle(2);
    step(1, '0, 0, '0, 0, 0);
    idle(3);
    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      p   = NSRC'($urandom & $urandom & $urandom);
      a   = ($urandom_range(0, 2) == 0);
      aid = (m_on && $urandom_range(0, 1) == 1) ? m_id : int'($urandom_range(0, 7));
      mw  = ($urandom_range(0, 19) == 0);
      md  = NSRC'($urandom | $urandom);
      r   = ($urandom_range(0, 299) == 0);
      step(r, p, mw, md, a, aid);
    end
    idle(2);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
